// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
package instruction_fetch_unit_pkg;

   // All-zero word presented in an empty or flushed IF/ID slot; decodes as NOP.
   localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0000;

   // Sequential fetch stride in bytes.
   localparam int unsigned PC_INCREMENT = 4;

   // Fetch sequencer states.
   typedef enum logic [1:0] {
      ST_ISSUE   = 2'd0,
      ST_WAIT    = 2'd1,
      ST_HOLD    = 2'd2,
      ST_DISCARD = 2'd3
   } ifu_state_e;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Pipeline front end: PC, single-outstanding instruction memory reads,
// IF/ID boundary registers with stall hold and redirect flush.
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter int unsigned           PC_WIDTH          = 32,
   parameter int unsigned           INSTRUCTION_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0]   RESET_PC          = '0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         stall_in,
   input  logic                         redirect_in,
   input  logic [PC_WIDTH-1:0]          redirect_pc_in,
   output logic                         imem_rd_en_out,
   output logic [PC_WIDTH-1:0]          imem_addr_out,
   input  logic [INSTRUCTION_WIDTH-1:0] imem_data_in,
   input  logic                         imem_valid_in,
   output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
   output logic [PC_WIDTH-1:0]          pc_plus4_out,
   output logic                         inst_valid_out
);

   localparam logic [INSTRUCTION_WIDTH-1:0] NOP_WORD  = INSTRUCTION_WIDTH'(NOP_INSTRUCTION);
   localparam logic [PC_WIDTH-1:0]          PC_STEP   = PC_WIDTH'(PC_INCREMENT);
   localparam logic [PC_WIDTH-1:0]          ALIGN_MSK = ~PC_WIDTH'(2'b11);

   ifu_state_e                   state;
   logic [PC_WIDTH-1:0]          pc_reg;
   logic [INSTRUCTION_WIDTH-1:0] hold_buf;
   logic [PC_WIDTH-1:0]          pc_next_seq;
   logic [PC_WIDTH-1:0]          redirect_pc_aligned;
   logic                         resp_pending;

   // Sequential next PC wraps naturally modulo 2^PC_WIDTH.
   assign pc_next_seq         = pc_reg + PC_STEP;
   assign redirect_pc_aligned = redirect_pc_in & ALIGN_MSK;

   // A response is still owed by memory only while waiting with nothing returned yet.
   assign resp_pending = ((state == ST_WAIT) || (state == ST_DISCARD)) && !imem_valid_in;

   // Request strobe and address are combinational off the current state and PC;
   // the strobe is held low during reset since memory is also in reset.
   assign imem_rd_en_out = (state == ST_ISSUE) && !redirect_in && rst_n;
   assign imem_addr_out  = pc_reg;

   // Fetch sequencer, PC, hold buffer and IF/ID registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= ST_ISSUE;
         pc_reg          <= RESET_PC;
         hold_buf        <= NOP_WORD;
         instruction_out <= NOP_WORD;
         pc_plus4_out    <= '0;
         inst_valid_out  <= 1'b0;
      end else if (redirect_in) begin
         // Redirect wins over stall: flush slot, reload PC, and skip any
         // response still owed for the abandoned request.
         pc_reg          <= redirect_pc_aligned;
         instruction_out <= NOP_WORD;
         inst_valid_out  <= 1'b0;
         hold_buf        <= NOP_WORD;
         state           <= resp_pending ? ST_DISCARD : ST_ISSUE;
      end else begin
         case (state)
            ST_ISSUE: begin
               state <= ST_WAIT;
               if (!stall_in) begin
                  instruction_out <= NOP_WORD;
                  inst_valid_out  <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (imem_valid_in) begin
                  if (!stall_in) begin
                     instruction_out <= imem_data_in;
                     pc_plus4_out    <= pc_next_seq;
                     inst_valid_out  <= 1'b1;
                     pc_reg          <= pc_next_seq;
                     state           <= ST_ISSUE;
                  end else begin
                     hold_buf <= imem_data_in;
                     state    <= ST_HOLD;
                  end
               end else if (!stall_in) begin
                  instruction_out <= NOP_WORD;
                  inst_valid_out  <= 1'b0;
               end
            end
            ST_HOLD: begin
               if (!stall_in) begin
                  instruction_out <= hold_buf;
                  pc_plus4_out    <= pc_next_seq;
                  inst_valid_out  <= 1'b1;
                  pc_reg          <= pc_next_seq;
                  state           <= ST_ISSUE;
               end
            end
            ST_DISCARD: begin
               if (imem_valid_in) begin
                  state <= ST_ISSUE;
               end
               if (!stall_in) begin
                  instruction_out <= NOP_WORD;
                  inst_valid_out  <= 1'b0;
               end
            end
            default: begin
               state <= ST_ISSUE;
            end
         endcase
      end
   end

endmodule
